serial_subtractor: RTL

Bit-serial two's-complement subtractor computing `a - b - bin` over WIDTH clock cycles with a start/done handshake. It is the sequential inverse-operation companion to the combinational ripple-carry adder. It trades latency for a single full-subtractor cell plus shift registers. It sits in the datapath where area matters more than throughput, and it also supplies the unsigned-less-than, zero and signed-overflow flags.

---
 rtl/serial_subtractor.sv | 96 +++++++++
 1 files changed

// File: rtl/serial_subtractor.sv
// Bit-serial two's-complement subtractor: diff = a - b - bin, one bit per clock,
// LSB first, with borrow-out, zero and signed-overflow flags on completion.
module serial_subtractor #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             bout,
  output logic             zero,
  output logic             ovf
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  localparam logic IDLE = 1'b0;
  localparam logic RUN  = 1'b1;

  logic             state;
  logic [WIDTH-1:0] sa;
  logic [WIDTH-1:0] sb;
  logic [WIDTH-1:0] res;
  logic             br;
  logic             msb_a;
  logic             msb_b;
  logic [CW-1:0]    cnt;

  logic             d;
  logic             br_next;
  logic [WIDTH-1:0] res_next;

  // Handshake: start is taken on any rising edge while idle (including the done
  // cycle); busy is high from the accepting edge until the result edge, where
  // done pulses for one cycle and the result outputs update and then hold.
  always_comb begin
    d        = sa[0] ^ sb[0] ^ br;
    br_next  = (~sa[0] & sb[0]) | (~(sa[0] ^ sb[0]) & br);
    res_next = {d, res[WIDTH-1:1]};
  end

  assign busy = (state == RUN);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      sa    <= '0;
      sb    <= '0;
      res   <= '0;
      br    <= 1'b0;
      msb_a <= 1'b0;
      msb_b <= 1'b0;
      cnt   <= '0;
      done  <= 1'b0;
      diff  <= '0;
      bout  <= 1'b0;
      zero  <= 1'b0;
      ovf   <= 1'b0;
    end else begin
      done <= 1'b0;
      if (state == IDLE) begin
        if (start) begin
          sa    <= a;
          sb    <= b;
          br    <= bin;
          msb_a <= a[WIDTH-1];
          msb_b <= b[WIDTH-1];
          cnt   <= '0;
          state <= RUN;
        end
      end else begin
        sa  <= sa >> 1;
        sb  <= sb >> 1;
        br  <= br_next;
        res <= res_next;
        cnt <= cnt + CW'(1);
        // The final bit is the result MSB, so it feeds the overflow term directly.
        if (cnt == LAST) begin
          state <= IDLE;
          diff  <= res_next;
          bout  <= br_next;
          zero  <= (res_next == '0);
          ovf   <= (msb_a ^ msb_b) & (msb_a ^ d);
          done  <= 1'b1;
        end
      end
    end
  end

endmodule
